// File: rtl/prelu_pkg.sv
// Shared types and constants for the PReLU sequencer and its datapath.
package prelu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Alpha of exactly 1.0 in the fixed-point format, used as the reset value.
  function automatic int reset_alpha(input int frac);
    return 1 << frac;
  endfunction

  function automatic int sat_hi(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/prelu_dp.sv
// Combinational PReLU: pass non-negative x, else floor(x*alpha / 2^FRAC) with saturation.
module prelu_dp
  import prelu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ALPHA_WIDTH = 8,
  parameter int ALPHA_FRAC  = 4
) (
  input  logic [WIDTH-1:0]       x,
  input  logic [ALPHA_WIDTH-1:0] alpha,
  output logic [WIDTH-1:0]       y
);

  localparam int PW = WIDTH + ALPHA_WIDTH + 1;
  localparam logic signed [PW-1:0] HI = PW'(sat_hi(WIDTH));
  localparam logic signed [PW-1:0] LO = PW'(sat_lo(WIDTH));

  logic signed [PW-1:0] xe, ae, p, sh;

  always_comb begin
    xe = {{(PW-WIDTH){x[WIDTH-1]}}, x};
    ae = {{(PW-ALPHA_WIDTH){1'b0}}, alpha};
    p  = xe * ae;
    // Arithmetic shift gives floor division for negative products.
    sh = p >>> ALPHA_FRAC;
    y  = x;
    if (x[WIDTH-1]) begin
      if (sh > HI)      y = HI[WIDTH-1:0];
      else if (sh < LO) y = LO[WIDTH-1:0];
      else              y = sh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/prelu_seq.sv
// PReLU sequencer: per-channel alpha file, vector FSM and one-stage output register with backpressure.
module prelu_seq
  import prelu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ALPHA_WIDTH = 8,
  parameter int ALPHA_FRAC  = 4,
  parameter int NUM_CH      = 4,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      vec_len,
  output logic                      busy,
  output logic                      done,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [ALPHA_WIDTH-1:0]    cfg_alpha,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last
);

  localparam int CW = $clog2(NUM_CH);
  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);
  localparam logic [1:0] S_DONE  = 2'(DONE);
  localparam logic [ALPHA_WIDTH-1:0] ALPHA_RST = ALPHA_WIDTH'(reset_alpha(ALPHA_FRAC));

  logic [1:0]                         state;
  logic [LEN_WIDTH-1:0]               remaining;
  logic [CW-1:0]                      elem_idx;
  logic [NUM_CH-1:0][ALPHA_WIDTH-1:0] alpha_q;
  logic [WIDTH-1:0]                   y;
  logic                               in_hs, out_hs, last_in;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_in  = (remaining == LEN_WIDTH'(1));

  prelu_dp #(
    .WIDTH      (WIDTH),
    .ALPHA_WIDTH(ALPHA_WIDTH),
    .ALPHA_FRAC (ALPHA_FRAC)
  ) u_dp (
    .x    (in_data),
    .alpha(alpha_q[elem_idx]),
    .y    (y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      elem_idx  <= '0;
      for (int c = 0; c < NUM_CH; c++) alpha_q[c] <= ALPHA_RST;
    end else begin
      // Alphas only change between vectors so a vector sees one consistent set.
      if (cfg_we && state == S_IDLE) alpha_q[cfg_addr] <= cfg_alpha;
      case (state)
        S_IDLE: if (start) begin
          remaining <= vec_len;
          elem_idx  <= '0;
          state     <= (vec_len == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (in_hs) begin
          remaining <= remaining - LEN_WIDTH'(1);
          elem_idx  <= elem_idx + CW'(1);
          if (last_in) state <= S_DRAIN;
        end
        S_DRAIN: if (out_hs && out_last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (in_hs) begin
      out_valid <= 1'b1;
      out_last  <= last_in;
      out_data  <= y;
    end else if (out_hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
